// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: PC, IR, MDR, A/B, ALUOut and register file.
// Driven each cycle by the controller's control word.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic        RegWrite,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ImmSrc,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        Zero
);

  logic [31:0] pc, oldpc, instr, data;
  logic [31:0] a, b, aluout;
  logic [31:0] rf [32];
  logic [31:0] rd1, rd2, immext;
  logic [31:0] srca, srcb, aluresult, result;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7b5  = instr[30];
  assign WriteData = b;

  // x0 is hardwired; reads see the array value before this edge's write
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Immediate extraction, sign taken from instr[31]
  always_comb begin
    immext = 32'd0;
    case (ImmSrc)
      3'b000: immext = {{20{instr[31]}}, instr[31:20]};
      3'b001: immext = {{20{instr[31]}}, instr[31:25],
                        instr[11:7]};
      3'b010: immext = {{20{instr[31]}}, instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      3'b011: immext = {{12{instr[31]}}, instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      3'b100: immext = {instr[31:12], 12'b0};
      default: immext = 32'd0;
    endcase
  end

  // ALU operand selection
  always_comb begin
    srca = 32'd0;
    srcb = 32'd0;
    case (ALUSrcA)
      2'b00:   srca = pc;
      2'b01:   srca = oldpc;
      2'b10:   srca = a;
      default: srca = 32'd0;
    endcase
    case (ALUSrcB)
      2'b00:   srcb = b;
      2'b01:   srcb = immext;
      2'b10:   srcb = 32'd4;
      default: srcb = 32'd0;
    endcase
  end

  // ALU: wraparound arithmetic, 5-bit shift amount
  always_comb begin
    aluresult = 32'd0;
    case (ALUControl)
      3'b000: aluresult = srca + srcb;
      3'b001: aluresult = srca - srcb;
      3'b010: aluresult = srca & srcb;
      3'b011: aluresult = srca | srcb;
      3'b100: aluresult = srca ^ srcb;
      3'b101: aluresult = {31'b0,
                           $signed(srca) < $signed(srcb)};
      3'b110: aluresult = srca << srcb[4:0];
      default: aluresult = srca >> srcb[4:0];
    endcase
  end

  assign Zero = (aluresult == 32'd0);

  // Result and memory address selection
  always_comb begin
    result = aluout;
    case (ResultSrc)
      2'b00:   result = aluout;
      2'b01:   result = data;
      2'b10:   result = aluresult;
      default: result = immext;
    endcase
  end

  assign Adr = AdrSrc ? result : pc;

  // Architectural and pipeline-style state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      oldpc  <= 32'd0;
      instr  <= 32'd0;
      data   <= 32'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      aluout <= 32'd0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) begin
        instr <= ReadData;
        oldpc <= pc;
      end
      data   <= ReadData;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
    end
  end

  // Register file write; survives reset
  always_ff @(posedge clk) begin
    if (RegWrite && (rd != 5'd0)) rf[rd] <= result;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath.
// Internal state is observed through Adr via the result muxes.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCWrite, IRWrite, AdrSrc, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc, ALUControl;
  logic [31:0] ReadData;
  logic [31:0] Adr, WriteData;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero;

  int checks = 0;
  int failures = 0;

  multicycle_datapath #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .ReadData(ReadData),
    .Adr(Adr), .WriteData(WriteData), .op(op),
    .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    PCWrite = 0; IRWrite = 0; AdrSrc = 0; RegWrite = 0;
    ResultSrc = 0; ALUSrcA = 0; ALUSrcB = 0;
    ImmSrc = 0; ALUControl = 0; ReadData = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins);
    idle();
    PCWrite = 1; IRWrite = 1; ALUSrcB = 2'b10;
    ResultSrc = 2'b10; ReadData = ins;
    tick();
    idle();
  endtask

  task automatic wb_imm(input logic [2:0] src);
    idle();
    RegWrite = 1; ResultSrc = 2'b11; ImmSrc = src;
    tick();
    idle();
  endtask

  task automatic show_pc();
    idle();
    #1;
  endtask

  task automatic show_oldpc();
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b01; ALUSrcB = 2'b11;
    #1;
  endtask

  task automatic show_imm(input logic [2:0] src);
    idle();
    AdrSrc = 1; ResultSrc = 2'b11; ImmSrc = src;
    #1;
  endtask

  task automatic show_aluout();
    idle();
    AdrSrc = 1; ResultSrc = 2'b00;
    #1;
  endtask

  task automatic show_a();
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b10; ALUSrcB = 2'b11;
    #1;
  endtask

  logic [31:0] alu_exp [8];

  initial begin
    idle();
    alu_exp[0] = 32'h0000_0000;
    alu_exp[1] = 32'hFFFF_FFFE;
    alu_exp[2] = 32'h0000_0001;
    alu_exp[3] = 32'hFFFF_FFFF;
    alu_exp[4] = 32'hFFFF_FFFE;
    alu_exp[5] = 32'h0000_0001;
    alu_exp[6] = 32'hFFFF_FFFE;
    alu_exp[7] = 32'h7FFF_FFFF;

    @(posedge clk);
    #4 reset = 1;
    #1;
    chk("rst_adr", Adr, 32'h100);
    chk("rst_wdata", WriteData, 32'h0);
    chk("rst_op", {25'b0, op}, 32'h0);
    chk("rst_funct3", {29'b0, funct3}, 32'h0);
    #2 reset = 0;
    tick();

    show_pc();
    chk("fetch_adr_pre", Adr, 32'h100);
    fetch(32'h0040_2083);
    chk("fetch_op", {25'b0, op}, 32'h03);
    chk("fetch_funct3", {29'b0, funct3}, 32'h2);
    show_pc();
    chk("fetch_pc", Adr, 32'h104);
    show_oldpc();
    chk("fetch_oldpc", Adr, 32'h100);

    idle();
    tick();
    ALUSrcA = 2'b10; ALUSrcB = 2'b01;
    tick();
    AdrSrc = 1; ResultSrc = 2'b00;
    #1;
    chk("lw_memadr", Adr, 32'h4);
    ReadData = 32'hDEAD_BEEF;
    tick();
    idle();
    RegWrite = 1; ResultSrc = 2'b01;
    tick();
    idle();

    fetch(32'h0200_0113);
    wb_imm(3'b000);
    fetch(32'hFE11_2C23);
    show_imm(3'b001);
    chk("sw_imm", Adr, 32'hFFFF_FFF8);
    idle();
    tick();
    #1;
    chk("sw_wdata", WriteData, 32'hDEAD_BEEF);
    ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 3'b001;
    tick();
    show_aluout();
    chk("sw_aluout", Adr, 32'h18);

    fetch(32'h0000_8033);
    tick();
    show_a();
    chk("x1_via_a", Adr, 32'hDEAD_BEEF);

    fetch(32'h0050_0193);
    wb_imm(3'b000);
    fetch(32'h0060_0213);
    wb_imm(3'b000);
    fetch(32'hFE31_8EE3);
    tick();
    ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUControl = 3'b001;
    #1;
    chk("beq_eq_zero", {31'b0, Zero}, 32'h1);
    show_imm(3'b010);
    chk("beq_imm", Adr, 32'hFFFF_FFFC);
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 3'b010;
    #1;
    chk("beq_target1", Adr, 32'h114);

    fetch(32'hFE41_8EE3);
    tick();
    ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUControl = 3'b001;
    #1;
    chk("beq_ne_zero", {31'b0, Zero}, 32'h0);
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 3'b010;
    #1;
    chk("beq_target2", Adr, 32'h118);

    fetch(32'hFFFF_FFFF);
    chk("ones_f7b5", {31'b0, funct7b5}, 32'h1);
    show_imm(3'b000); chk("ones_i", Adr, 32'hFFFF_FFFF);
    show_imm(3'b001); chk("ones_s", Adr, 32'hFFFF_FFFF);
    show_imm(3'b010); chk("ones_b", Adr, 32'hFFFF_FFFE);
    show_imm(3'b011); chk("ones_j", Adr, 32'hFFFF_FFFE);
    show_imm(3'b100); chk("ones_u", Adr, 32'hFFFF_F000);
    show_imm(3'b101); chk("ones_bad", Adr, 32'h0);

    fetch(32'h1234_5678);
    chk("pat_f7b5", {31'b0, funct7b5}, 32'h0);
    show_imm(3'b000); chk("pat_i", Adr, 32'h0000_0123);
    show_imm(3'b001); chk("pat_s", Adr, 32'h0000_012C);
    show_imm(3'b010); chk("pat_b", Adr, 32'h0000_012C);
    show_imm(3'b011); chk("pat_j", Adr, 32'h0004_5922);
    show_imm(3'b100); chk("pat_u", Adr, 32'h1234_5000);

    fetch(32'h0550_0013);
    wb_imm(3'b000);
    tick();
    show_a();
    chk("x0_read", Adr, 32'h0);

    fetch(32'h8000_02B7);
    wb_imm(3'b100);
    fetch(32'h0012_8013);
    tick();
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b10; ALUSrcB = 2'b01;
    ALUControl = 3'b101;
    #1;
    chk("slt_signed", Adr, 32'h1);
    chk("slt_zero", {31'b0, Zero}, 32'h0);

    fetch(32'hFFF0_0313);
    wb_imm(3'b000);
    fetch(32'h0013_0013);
    tick();
    idle();
    AdrSrc = 1; ResultSrc = 2'b10;
    ALUSrcA = 2'b10; ALUSrcB = 2'b01;
    for (int i = 0; i < 8; i++) begin
      ALUControl = 3'(i);
      #1;
      chk($sformatf("alu_op%0d", i), Adr, alu_exp[i]);
      if (i == 0) chk("add_wrap_zero", {31'b0, Zero}, 32'h1);
    end

    idle();
    ALUSrcA = 2'b10;
    #2 reset = 1;
    #1;
    chk("rst2_adr", Adr, 32'h100);
    chk("rst2_wdata", WriteData, 32'h0);
    chk("rst2_f7b5", {31'b0, funct7b5}, 32'h0);
    #2 reset = 0;
    fetch(32'h0000_8033);
    show_pc();
    chk("rst2_pc", Adr, 32'h104);
    tick();
    show_a();
    chk("rst2_x1_kept", Adr, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
